// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver feeding a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing; default build is 8N1.
module uart_rx_fifo #(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int BAUD_RATE       = 115_200,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx,
    output logic [7:0]                 rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
    output logic                       frame_err,
    output logic                       overflow,
    input  logic                       ovf_clr
);
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * 16);
    localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI
    } state_t;
`endif

    state_t        r_state;
    logic          r_s1, r_s2;
    logic [PW-1:0] r_pre;
    logic [3:0]    r_sc;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_ferr;
`ifdef UART_RX_PARITY_EN
    logic          r_perr;
`endif

    logic          w_rxs;
    logic          w_wrap;
    logic          w_tick;
    logic          w_stop_ok;
    logic          w_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= rx;
            r_s2 <= r_s1;
        end
    end

    assign w_rxs  = r_s2;
    assign w_wrap = (r_pre == PRE_MAX);
    assign w_tick = w_wrap && (r_state != S_IDLE);

    // Prescaler parks at 0 in IDLE so every frame starts phase-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pre <= '0;
        else if (r_state == S_IDLE || w_wrap)
            r_pre <= '0;
        else
            r_pre <= r_pre + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sc    <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            r_ferr <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_sc    <= '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_sc == 4'd7) begin
                            r_sc    <= '0;
                            r_bit   <= '0;
                            r_state <= w_rxs ? S_IDLE : S_DATA;
                        end else begin
                            r_sc <= r_sc + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_sc <= r_sc + 4'd1;
                        if (r_sc == 4'hF) begin
                            r_shift <= {w_rxs, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_sc <= r_sc + 4'd1;
                        if (r_sc == 4'hF) begin
                            r_perr  <= ^{r_shift, w_rxs};
                            r_state <= S_STOP;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        r_sc <= r_sc + 4'd1;
                        if (r_sc == 4'hF) begin
                            if (!w_rxs) begin
                                r_ferr  <= 1'b1;
                                r_state <= S_WAIT_HI;
                            end else begin
`ifdef UART_RX_PARITY_EN
                                r_ferr  <= r_perr;
`endif
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                S_WAIT_HI: begin
                    if (w_rxs)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_stop_ok = w_tick && (r_state == S_STOP) &&
                       (r_sc == 4'hF) && w_rxs;
`ifdef UART_RX_PARITY_EN
    assign w_push = w_stop_ok && !r_perr;
`else
    assign w_push = w_stop_ok;
`endif

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count;
    logic [7:0]    r_data;
    logic          r_ovf;

    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic [AW-1:0] w_rp_nx;

    assign w_full  = (r_count == CNT_FULL);
    assign w_pop   = (r_count != '0) && rx_ready;
    assign w_wr    = w_push && !w_full;
    assign w_rp_nx = r_rp + 1'b1;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wp] <= r_shift;
    end

    // Head register only moves on a pop or when the first byte lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= w_rp_nx;
            if (w_wr && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_wr)
                r_count <= r_count - 1'b1;
            if (w_pop && r_count > CNT_ONE)
                r_data <= r_mem[w_rp_nx];
            else if (w_wr && (r_count == '0 ||
                              (w_pop && r_count == CNT_ONE)))
                r_data <= r_shift;
            if (w_push && w_full)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = (r_count != '0);
    assign fifo_count = r_count;
    assign frame_err  = r_ferr;
    assign overflow   = r_ovf;

endmodule
